// File: rtl/demux_latch.sv
// demux_latch: registered 1-to-4 demultiplexer driven by a debounced button.
// A qualified press (btn_db rising) loads D into output Y[S].
// Optional build macro DEMUX_TOGGLE_EN: a write inverts Y[S] instead of loading D.
//
// Handshake: wr_stb is a valid-only, one-cycle strobe. It is high for the cycle
// after a write edge, and Y0..Y3/sel_q already hold the written values while it
// is high. There is no ready/back-pressure; a downstream consumer must sample
// on the strobe.
module demux_latch #(
  parameter int WIDTH      = 1,
  parameter int DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       S,
  input  logic             btn,
  input  logic             clr,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y3,
  output logic             wr_stb,
  output logic [1:0]       sel_q
);

  logic             sync1;
  logic             btn_s;
  logic             btn_db;
  logic [7:0]       cnt;
  logic             mismatch;
  logic             flip;
  logic             write;
  logic [WIDTH-1:0] y_q [4];

  // The debounced level flips once btn_s has disagreed with it for DEB_CYCLES edges.
  assign mismatch = (btn_s != btn_db);
  assign flip     = mismatch && (cnt == 8'(DEB_CYCLES - 1));
  // Only a press (0->1 flip) writes; a release never does.
  assign write    = flip && !btn_db;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= btn;
      btn_s <= sync1;
    end
  end

  // Debounce counter and debounced level; clr deliberately does not touch these.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_db <= 1'b0;
      cnt    <= 8'd0;
    end else if (!mismatch) begin
      cnt    <= 8'd0;
    end else if (flip) begin
      btn_db <= ~btn_db;
      cnt    <= 8'd0;
    end else begin
      cnt    <= cnt + 8'd1;
    end
  end

  // Output registers: clr wins over a coincident write, which is then dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) y_q[i] <= '0;
      sel_q  <= 2'd0;
      wr_stb <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < 4; i++) y_q[i] <= '0;
      sel_q  <= 2'd0;
      wr_stb <= 1'b0;
    end else begin
      wr_stb <= write;
      if (write) begin
`ifdef DEMUX_TOGGLE_EN
        y_q[S] <= ~y_q[S];
`else
        y_q[S] <= D;
`endif
        sel_q  <= S;
      end
    end
  end

  assign Y0 = y_q[0];
  assign Y1 = y_q[1];
  assign Y2 = y_q[2];
  assign Y3 = y_q[3];

endmodule

// File: tb/tb_demux_latch.sv
// Testbench for demux_latch (WIDTH=1, DEB_CYCLES=4). Honors DEMUX_TOGGLE_EN.
module tb_demux_latch;

  localparam int WIDTH = 1;
  localparam int DEB   = 4;
  localparam int EW    = 16 + 2 + 4 * WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] D = '0;
  logic [1:0]       S = 2'd0;
  logic             btn = 1'b0;
  logic             clr = 1'b0;
  logic [WIDTH-1:0] Y0, Y1, Y2, Y3;
  logic             wr_stb;
  logic [1:0]       sel_q;

  demux_latch #(.WIDTH(WIDTH), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .D(D), .S(S), .btn(btn), .clr(clr),
    .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3), .wr_stb(wr_stb), .sel_q(sel_q)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // Button path: btn_s at edge k is the raw btn seen at edge k-2.
  // Debounced level flips when the last DEB btn_s samples since the previous
  // flip all disagree with it. Writes go into an expectation queue stamped
  // with the edge number at which they happen.
  logic [EW-1:0]    exp_q[$];
  logic             raw_q[$];
  logic             bs_q[$];
  logic             m_db;
  logic [WIDTH-1:0] ym [4];
  logic [1:0]       m_sel;
  logic             m_stb;

  always @(posedge clk or negedge rst) begin
    logic bs, all_diff, wr;
    if (!rst) begin
      raw_q.delete();
      bs_q.delete();
      m_db = 1'b0;
      for (int i = 0; i < 4; i++) ym[i] = '0;
      m_sel = 2'd0;
      m_stb = 1'b0;
    end else begin
      bs = (raw_q.size() >= 2) ? raw_q[raw_q.size() - 2] : 1'b0;
      raw_q.push_back(btn);
      if (raw_q.size() > 2) void'(raw_q.pop_front());
      bs_q.push_back(bs);
      if (bs_q.size() > DEB) void'(bs_q.pop_front());
      all_diff = (bs_q.size() == DEB);
      foreach (bs_q[i]) if (bs_q[i] == m_db) all_diff = 1'b0;
      wr = 1'b0;
      if (all_diff) begin
        m_db = ~m_db;
        bs_q.delete();
        wr = m_db;
      end
      if (clr) begin
        for (int i = 0; i < 4; i++) ym[i] = '0;
        m_sel = 2'd0;
        m_stb = 1'b0;
      end else begin
        m_stb = wr;
        if (wr) begin
`ifdef DEMUX_TOGGLE_EN
          ym[S] = ~ym[S];
`else
          ym[S] = D;
`endif
          m_sel = S;
          exp_q.push_back({16'(cyc), m_sel, ym[3], ym[2], ym[1], ym[0]});
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  // On every strobe, pop the oldest expectation and compare edge stamp,
  // sel_q and all four outputs. Stale expectations mean a missed strobe.
  always @(negedge clk) begin
    logic [EW-1:0] act, e;
    if (rst) begin
      while (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 16]) < cyc - 1) begin
        e = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missing_strobe: no wr_stb, expected write at edge %0d", int'(e[EW-1 -: 16]));
      end
      if (wr_stb) begin
        act = {16'(cyc - 1), sel_q, Y3, Y2, Y1, Y0};
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_strobe: got %h, required no strobe", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            miscompares++;
            $display("FAIL strobe_data: got {edge,sel,Y3..Y0}=%h, required %h", act, e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Compare all held outputs against the model.
  task automatic check_outputs(input string tag);
    chk({tag, "_y0"}, int'(Y0), int'(ym[0]));
    chk({tag, "_y1"}, int'(Y1), int'(ym[1]));
    chk({tag, "_y2"}, int'(Y2), int'(ym[2]));
    chk({tag, "_y3"}, int'(Y3), int'(ym[3]));
    chk({tag, "_sel"}, int'(sel_q), int'(m_sel));
    chk({tag, "_stb"}, int'(wr_stb), int'(m_stb));
  endtask

  // Count ticks until wr_stb is seen (bounded); -1 if it never appears.
  task automatic wait_strobe(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick(1);
      if (wr_stb && n < 0) n = i;
      if (n >= 0) break;
    end
  endtask

  task automatic press(input logic [1:0] s, input logic [WIDTH-1:0] d);
    S = s;
    D = d;
    btn = 1'b1;
    tick(8);
    btn = 1'b0;
    tick(8);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, strobes;
    logic lvl;
    int seg;

    // Reset and idle
    rst = 1'b0;
    tick(3);
    chk("reset_y", int'({Y3, Y2, Y1, Y0}), 0);
    chk("reset_stb", int'(wr_stb), 0);
    chk("reset_sel", int'(sel_q), 0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check_outputs("idle");
    end

`ifdef DEMUX_TOGGLE_EN
    // Two presses on S=0 invert Y0 each time regardless of D
    press(2'd0, 1'b0);
    chk("toggle_first", int'(Y0), 1);
    press(2'd0, 1'b1);
    chk("toggle_second", int'(Y0), 0);
`endif

    // Single held press: latency and no auto-repeat
    D = 1'b1;
    S = 2'd2;
    btn = 1'b1;
    wait_strobe(12, n);
    chk("press_latency", n, DEB + 2);
`ifndef DEMUX_TOGGLE_EN
    chk("press_y2", int'(Y2), 1);
    chk("press_others", int'({Y3, Y1, Y0}), 0);
`endif
    chk("press_sel", int'(sel_q), 2);
    tick(1);
    chk("press_stb_one_cycle", int'(wr_stb), 0);
    tick(20);
    check_outputs("held");
    btn = 1'b0;
    tick(10);

    // Bounce shorter than the qualification window
    btn = 1'b1; tick(2);
    btn = 1'b0; tick(1);
    btn = 1'b1; tick(1);
    btn = 1'b0; tick(12);
    check_outputs("bounce");
    chk("bounce_db", int'(m_db), 0);

    // Four presses
    press(2'd0, 1'b1);
    press(2'd1, 1'b0);
    press(2'd2, 1'b1);
    press(2'd3, 1'b1);
`ifndef DEMUX_TOGGLE_EN
    chk("four_y", int'({Y3, Y2, Y1, Y0}), 4'b1101);
`endif
    chk("four_sel", int'(sel_q), 3);
    check_outputs("four");

    // clr on the write edge drops the write
    S = 2'd1;
    D = 1'b1;
    btn = 1'b1;
    tick(5);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_write_y1", int'(Y1), 0);
    chk("clr_write_stb", int'(wr_stb), 0);
    tick(10);
    btn = 1'b0;
    tick(10);
    press(2'd2, 1'b1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_alone_y", int'({Y3, Y2, Y1, Y0}), 0);
    chk("clr_alone_sel", int'(sel_q), 0);
    check_outputs("clr");

    // Reset mid-debounce with btn still held
    S = 2'd3;
    D = 1'b1;
    btn = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("midrst_y", int'({Y3, Y2, Y1, Y0}), 0);
    rst = 1'b1;
    wait_strobe(12, n);
    chk("midrst_latency", n, DEB + 2);
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (wr_stb) strobes++;
    end
    chk("midrst_single_write", strobes, 0);
    btn = 1'b0;
    tick(10);

    // Randomized: bouncing button segments, random D/S every cycle, sparse clr
    lvl = 1'b0;
    for (int k = 0; k < 200; k++) begin
      lvl = ~lvl;
      seg = ($urandom_range(0, 3) == 0) ? $urandom_range(DEB + 2, DEB + 10)
                                        : $urandom_range(1, DEB + 2);
      for (int j = 0; j < seg; j++) begin
        btn = lvl;
        D = WIDTH'($urandom);
        S = 2'($urandom_range(0, 3));
        clr = ($urandom_range(0, 29) == 0);
        tick(1);
        check_outputs("rand");
      end
    end
    clr = 1'b0;
    btn = 1'b0;
    tick(12);
    check_outputs("final");
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

endmodule
